ddr_burst_port: RTL and testbench
=================================

DDR_BURST_PORT -- requirements
Module: ddr_burst_port

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- DATA_WIDTH, 16, width of one data beat.
- DDR_ADDR_WIDTH, 28, byte address width.
- BURST_LEN, 16, beats per data burst; equals the cache depth.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, clock.
- rst, in, 1, asynchronous active-low reset.
- DATA_read_req, in, 1, cache requests a data read burst.
- DATA_store_req, in, 1, cache requests a data write burst.
- JMP_ADDR_read_req, in, 1, cache requests a jump-address read.
- DATA_read_addr, in, DDR_ADDR_WIDTH, read base address.
- DATA_write_addr, in, DDR_ADDR_WIDTH, write base address.
- DATA_to_ddr, in, DATA_WIDTH, write beat from the cache.
- data_to_ddr_rdy, in, 1, DATA_to_ddr is valid.
- DATA_to_cache, out, DATA_WIDTH, read beat to the cache.
- JMP_ADDR_to_cache, out, DDR_ADDR_WIDTH, assembled jump address.
- rd_cnt_data, out, 10, read beat counter.
- rd_burst_data_valid, out, 1, DATA_to_cache is valid.
- wr_burst_data_req, out, 1, this cycle consumes a write beat.
- state_interface_module, out, 4, current state code.
- mem_cmd_valid, out, 1, command to memory is valid.
- mem_cmd_ready, in, 1, memory accepts the command.
- mem_cmd_we, out, 1, 1 = write command.
- mem_cmd_addr, out, DDR_ADDR_WIDTH, command address.
- mem_cmd_len, out, 10, beats in the command.
- mem_rd_valid, in, 1, memory read beat is valid.
- mem_rd_data, in, DATA_WIDTH, memory read beat.
- mem_wr_ready, in, 1, memory accepts a write beat.
- mem_wr_valid, out, 1, write beat is valid.
- mem_wr_data, out, DATA_WIDTH, write beat.

Function
REQ-003 The FSM SHALL have these states, and state_interface_module SHALL equal the state code: IDLE=0, MEM_READ_DATA=1, MEM_READ_JMP=2, MEM_WRITE_DATA_STORE=9, DONE=10.
REQ-004 In IDLE, request priority SHALL be DATA_store_req, then DATA_read_req, then JMP_ADDR_read_req, and the FSM SHALL go to the matching state.
REQ-005 On entering a transfer state, the block SHALL drive mem_cmd_valid=1 with the address registered at IDLE exit.
- Length: BURST_LEN for data, 2 for jump.
- mem_cmd_we=1 for write only.
- mem_cmd_valid SHALL hold until the cycle mem_cmd_ready=1, and SHALL be 0 after that.
REQ-006 The block SHALL not accept a new command or change state while mem_cmd_valid is unacknowledged.
REQ-007 Reads: each mem_rd_valid beat SHALL be registered onto DATA_to_cache with rd_burst_data_valid=1, one cycle latency, and rd_cnt_data SHALL increment by 1 in the same cycle.
REQ-008 rd_cnt_data SHALL clear to 0 on leaving IDLE.
- After the BURST_LEN-th data beat, the FSM SHALL enter DONE and rd_cnt_data SHALL increment once more, to BURST_LEN+1.
- rd_cnt_data SHALL hold that value until return to IDLE.
REQ-009 mem_rd_valid outside a read state SHALL be ignored, with no counter change and no valid pulse.
REQ-010 Jump reads: beat 0 SHALL supply JMP_ADDR_to_cache[15:0], and beat 1 SHALL supply [DDR_ADDR_WIDTH-1:16] from its low bits.
- rd_burst_data_valid and rd_cnt_data SHALL behave as for data reads, with burst length 2.
- JMP_ADDR_to_cache SHALL hold its value until the next jump read completes.
REQ-011 Writes: in MEM_WRITE_DATA_STORE after command acceptance, wr_burst_data_req SHALL be 1 exactly when mem_wr_ready=1, data_to_ddr_rdy=1 and fewer than BURST_LEN beats have been sent.
- In such a cycle, mem_wr_valid=1 and mem_wr_data=DATA_to_ddr, combinationally.
- A write beat SHALL never be issued without data_to_ddr_rdy.
REQ-012 After BURST_LEN write beats, the FSM SHALL enter DONE, and wr_burst_data_req SHALL be 0 from then on.
REQ-013 DONE SHALL return to IDLE in the first cycle where every request input is 0, and SHALL stay in DONE while the originating request stays high.
- This prevents re-triggering on a held request.
REQ-014 A request dropping mid-burst SHALL NOT abort the burst; the remaining beats SHALL complete and be discarded or sent as specified above.

Reset
REQ-015 On rst=0, asynchronously:
- State IDLE.
- All outputs 0, including rd_cnt_data, JMP_ADDR_to_cache and state_interface_module.
- Beat counters cleared.
REQ-016 Reset mid-burst SHALL abandon the burst; after rst=1 the block SHALL wait in IDLE for a fresh request.

Verification
REQ-017 Data read at DATA_read_addr=0x80, memory returns 0x1000..0x100F:
- mem_cmd addr=0x80, len=16, we=0.
- 16 valid pulses carry 0x1000..0x100F, with rd_cnt_data 1..16.
- Then DONE and rd_cnt_data=17.
REQ-018 Write at 0x400 with mem_wr_ready toggling every cycle and data_to_ddr_rdy=1:
- Exactly 16 wr_burst_data_req pulses, each aligned to mem_wr_ready=1.
- state_interface_module=9 throughout the beats.
REQ-019 Jump read, beats 0xBEEF then 0x0ABC -> JMP_ADDR_to_cache=0xABCBEEF, rd_cnt_data=3 in DONE.
REQ-020 DATA_store_req and DATA_read_req rise in the same cycle -> the write is served first, then after DONE and IDLE the read is served.
REQ-021 mem_cmd_ready held 0 for 5 cycles -> mem_cmd_valid stays 1 and the address is stable throughout.
REQ-022 rst pulsed low after 7 read beats -> all outputs 0 immediately, state 0, and a new read restarts at rd_cnt_data=1.

Source files
------------

// File: rtl/ddr_burst_port.sv
// rtl/ddr_burst_port.sv - burst port between the cache and a command/data memory interface
module ddr_burst_port #(
   parameter int DATA_WIDTH     = 16,
   parameter int DDR_ADDR_WIDTH = 28,
   parameter int BURST_LEN      = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      DATA_read_req,
   input  logic                      DATA_store_req,
   input  logic                      JMP_ADDR_read_req,
   input  logic [DDR_ADDR_WIDTH-1:0] DATA_read_addr,
   input  logic [DDR_ADDR_WIDTH-1:0] DATA_write_addr,
   input  logic [DATA_WIDTH-1:0]     DATA_to_ddr,
   input  logic                      data_to_ddr_rdy,
   output logic [DATA_WIDTH-1:0]     DATA_to_cache,
   output logic [DDR_ADDR_WIDTH-1:0] JMP_ADDR_to_cache,
   output logic [9:0]                rd_cnt_data,
   output logic                      rd_burst_data_valid,
   output logic                      wr_burst_data_req,
   output logic [3:0]                state_interface_module,
   output logic                      mem_cmd_valid,
   input  logic                      mem_cmd_ready,
   output logic                      mem_cmd_we,
   output logic [DDR_ADDR_WIDTH-1:0] mem_cmd_addr,
   output logic [9:0]                mem_cmd_len,
   input  logic                      mem_rd_valid,
   input  logic [DATA_WIDTH-1:0]     mem_rd_data,
   input  logic                      mem_wr_ready,
   output logic                      mem_wr_valid,
   output logic [DATA_WIDTH-1:0]     mem_wr_data
);

   typedef enum logic [3:0] {
      IDLE                 = 4'd0,
      MEM_READ_DATA        = 4'd1,
      MEM_READ_JMP         = 4'd2,
      MEM_WRITE_DATA_STORE = 4'd9,
      DONE                 = 4'd10
   } state_t;

   localparam int WCW = $clog2(BURST_LEN + 1);

   state_t           state, state_next;
   logic [WCW-1:0]   wr_cnt;
   logic [15:0]      jmp_lo;
   logic             rd_beat;
   logic             wr_beat;
   logic             leave_idle;

   assign state_interface_module = state;
   assign leave_idle             = (state == IDLE) && (state_next != IDLE);

   // State register; reset abandons any burst in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_next;
   end

   // Next state and beat qualification; no beat moves until the command is accepted.
   always_comb begin
      state_next        = state;
      rd_beat           = 1'b0;
      wr_beat           = 1'b0;
      wr_burst_data_req = 1'b0;
      mem_wr_valid      = 1'b0;
      mem_wr_data       = '0;
      case (state)
         IDLE: begin
            if (DATA_store_req)         state_next = MEM_WRITE_DATA_STORE;
            else if (DATA_read_req)     state_next = MEM_READ_DATA;
            else if (JMP_ADDR_read_req) state_next = MEM_READ_JMP;
         end
         MEM_READ_DATA: begin
            if (!mem_cmd_valid && mem_rd_valid) begin
               rd_beat = 1'b1;
               if (rd_cnt_data == 10'(BURST_LEN - 1)) state_next = DONE;
            end
         end
         MEM_READ_JMP: begin
            if (!mem_cmd_valid && mem_rd_valid) begin
               rd_beat = 1'b1;
               if (rd_cnt_data == 10'd1) state_next = DONE;
            end
         end
         MEM_WRITE_DATA_STORE: begin
            if (!mem_cmd_valid && mem_wr_ready && data_to_ddr_rdy && (wr_cnt < WCW'(BURST_LEN))) begin
               wr_beat           = 1'b1;
               wr_burst_data_req = 1'b1;
               mem_wr_valid      = 1'b1;
               mem_wr_data       = DATA_to_ddr;
               if (wr_cnt == WCW'(BURST_LEN - 1)) state_next = DONE;
            end
         end
         DONE: begin
            // Wait for all requests to drop so a held request cannot retrigger.
            if (!DATA_store_req && !DATA_read_req && !JMP_ADDR_read_req) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Command issue, read capture, beat counters and jump-address assembly.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_cmd_valid       <= 1'b0;
         mem_cmd_we          <= 1'b0;
         mem_cmd_addr        <= '0;
         mem_cmd_len         <= '0;
         rd_cnt_data         <= '0;
         rd_burst_data_valid <= 1'b0;
         DATA_to_cache       <= '0;
         JMP_ADDR_to_cache   <= '0;
         jmp_lo              <= '0;
         wr_cnt              <= '0;
      end else begin
         rd_burst_data_valid <= rd_beat;
         if (leave_idle) begin
            mem_cmd_valid <= 1'b1;
            mem_cmd_we    <= (state_next == MEM_WRITE_DATA_STORE);
            mem_cmd_addr  <= DATA_store_req ? DATA_write_addr : DATA_read_addr;
            mem_cmd_len   <= (state_next == MEM_READ_JMP) ? 10'd2 : 10'(BURST_LEN);
            rd_cnt_data   <= '0;
            wr_cnt        <= '0;
         end else begin
            if (mem_cmd_valid && mem_cmd_ready) mem_cmd_valid <= 1'b0;
            if (rd_beat) begin
               rd_cnt_data   <= rd_cnt_data + 10'd1;
               DATA_to_cache <= mem_rd_data;
               if (state == MEM_READ_JMP) begin
                  if (rd_cnt_data == 10'd0) jmp_lo <= mem_rd_data[15:0];
                  else JMP_ADDR_to_cache <= {mem_rd_data[DDR_ADDR_WIDTH-17:0], jmp_lo};
               end
            end else if (state == DONE && !mem_cmd_we && rd_cnt_data == mem_cmd_len) begin
               // One extra count marks burst completion for the cache.
               rd_cnt_data <= rd_cnt_data + 10'd1;
            end
            if (wr_beat) wr_cnt <= wr_cnt + WCW'(1);
         end
      end
   end

endmodule

// File: tb/tb_ddr_burst_port.sv
// tb/tb_ddr_burst_port.sv - randomized self-checking bench for ddr_burst_port
module tb_ddr_burst_port;
   logic        clk = 1'b0;
   logic        rst;
   logic        DATA_read_req, DATA_store_req, JMP_ADDR_read_req;
   logic [27:0] DATA_read_addr, DATA_write_addr;
   logic [15:0] DATA_to_ddr;
   logic        data_to_ddr_rdy;
   logic [15:0] DATA_to_cache;
   logic [27:0] JMP_ADDR_to_cache;
   logic [9:0]  rd_cnt_data;
   logic        rd_burst_data_valid, wr_burst_data_req;
   logic [3:0]  state_interface_module;
   logic        mem_cmd_valid, mem_cmd_ready, mem_cmd_we;
   logic [27:0] mem_cmd_addr;
   logic [9:0]  mem_cmd_len;
   logic        mem_rd_valid;
   logic [15:0] mem_rd_data;
   logic        mem_wr_ready, mem_wr_valid;
   logic [15:0] mem_wr_data;

   int          total = 0;
   int          bad = 0;
   logic [27:0] jmp_model = '0;

   ddr_burst_port #(.DATA_WIDTH(16), .DDR_ADDR_WIDTH(28), .BURST_LEN(16)) dut (
      .clk(clk), .rst(rst),
      .DATA_read_req(DATA_read_req), .DATA_store_req(DATA_store_req),
      .JMP_ADDR_read_req(JMP_ADDR_read_req),
      .DATA_read_addr(DATA_read_addr), .DATA_write_addr(DATA_write_addr),
      .DATA_to_ddr(DATA_to_ddr), .data_to_ddr_rdy(data_to_ddr_rdy),
      .DATA_to_cache(DATA_to_cache), .JMP_ADDR_to_cache(JMP_ADDR_to_cache),
      .rd_cnt_data(rd_cnt_data), .rd_burst_data_valid(rd_burst_data_valid),
      .wr_burst_data_req(wr_burst_data_req),
      .state_interface_module(state_interface_module),
      .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready),
      .mem_cmd_we(mem_cmd_we), .mem_cmd_addr(mem_cmd_addr), .mem_cmd_len(mem_cmd_len),
      .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
      .mem_wr_ready(mem_wr_ready), .mem_wr_valid(mem_wr_valid), .mem_wr_data(mem_wr_data)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drop_reqs;
      DATA_read_req = 1'b0;
      DATA_store_req = 1'b0;
      JMP_ADDR_read_req = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_st"}, 32'(state_interface_module), 0);
      check({tag, "_dat"}, 32'(DATA_to_cache), 0);
      check({tag, "_jmp"}, 32'(JMP_ADDR_to_cache), 0);
      check({tag, "_cnt"}, 32'(rd_cnt_data), 0);
      check({tag, "_rv"}, 32'(rd_burst_data_valid), 0);
      check({tag, "_wrq"}, 32'(wr_burst_data_req), 0);
      check({tag, "_cv"}, 32'(mem_cmd_valid), 0);
      check({tag, "_cwe"}, 32'(mem_cmd_we), 0);
      check({tag, "_ca"}, 32'(mem_cmd_addr), 0);
      check({tag, "_cl"}, 32'(mem_cmd_len), 0);
      check({tag, "_wv"}, 32'(mem_wr_valid), 0);
      check({tag, "_wd"}, 32'(mem_wr_data), 0);
   endtask

   // mode: 0 random beats, 1 beats 0x1000+i, 2 jump beats 0xBEEF/0x0ABC
   task automatic rd_txn(input bit jmp, input logic [27:0] addr, input int cmd_delay,
                         input bit hold_req, input int abort_at, input int mode);
      int          n;
      logic [15:0] beats [16];
      n = jmp ? 2 : 16;
      for (int i = 0; i < 16; i++)
         beats[i] = (mode == 1) ? 16'(16'h1000 + i) :
                    (mode == 2) ? ((i == 0) ? 16'hBEEF : 16'h0ABC) : 16'($urandom);
      DATA_read_addr = addr;
      if (jmp) JMP_ADDR_read_req = 1'b1;
      else     DATA_read_req = 1'b1;
      tick;
      check("rd_state", 32'(state_interface_module), jmp ? 2 : 1);
      check("rd_cmd_v", 32'(mem_cmd_valid), 1);
      check("rd_cmd_a", 32'(mem_cmd_addr), 32'(addr));
      check("rd_cmd_len", 32'(mem_cmd_len), n);
      check("rd_cmd_we", 32'(mem_cmd_we), 0);
      check("rd_cnt0", 32'(rd_cnt_data), 0);
      if (!hold_req) drop_reqs();
      DATA_read_addr = 28'($urandom);
      repeat (cmd_delay) begin
         tick;
         check("rd_cmd_hold_v", 32'(mem_cmd_valid), 1);
         check("rd_cmd_hold_a", 32'(mem_cmd_addr), 32'(addr));
         check("rd_cmd_hold_st", 32'(state_interface_module), jmp ? 2 : 1);
      end
      mem_cmd_ready = 1'b1;
      tick;
      mem_cmd_ready = 1'b0;
      check("rd_cmd_ack", 32'(mem_cmd_valid), 0);
      for (int i = 0; i < n; i++) begin
         repeat ($urandom_range(0, 2)) begin
            tick;
            check("rd_gap_v", 32'(rd_burst_data_valid), 0);
         end
         mem_rd_valid = 1'b1;
         mem_rd_data = beats[i];
         tick;
         mem_rd_valid = 1'b0;
         mem_rd_data = 16'($urandom);
         check("rd_v", 32'(rd_burst_data_valid), 1);
         check("rd_data", 32'(DATA_to_cache), 32'(beats[i]));
         check("rd_cnt", 32'(rd_cnt_data), i + 1);
         if (jmp && i == 0) check("jmp_hold", 32'(JMP_ADDR_to_cache), 32'(jmp_model));
         if (i + 1 == abort_at) begin
            #2 rst = 1'b0;
            #1;
            jmp_model = '0;
            check_all_zero("rst_mid");
            drop_reqs();
            @(negedge clk) rst = 1'b1;
            mem_rd_valid = 1'b1;
            tick;
            mem_rd_valid = 1'b0;
            tick;
            check("rst_idle_st", 32'(state_interface_module), 0);
            check("rst_idle_v", 32'(rd_burst_data_valid), 0);
            check("rst_idle_cnt", 32'(rd_cnt_data), 0);
            return;
         end
      end
      if (jmp) jmp_model = {beats[1][11:0], beats[0]};
      check("rd_done_st", 32'(state_interface_module), 10);
      mem_rd_valid = 1'b1;
      tick;
      mem_rd_valid = 1'b0;
      check("rd_stray_v", 32'(rd_burst_data_valid), 0);
      check("rd_cnt_fin", 32'(rd_cnt_data), n + 1);
      if (hold_req) begin
         repeat (3) tick;
         check("rd_done_hold", 32'(state_interface_module), 10);
         check("rd_cnt_hold", 32'(rd_cnt_data), n + 1);
         drop_reqs();
      end
      tick;
      check("rd_back_idle", 32'(state_interface_module), 0);
      check("rd_cnt_idle", 32'(rd_cnt_data), n + 1);
      check("jmp_addr", 32'(JMP_ADDR_to_cache), 32'(jmp_model));
   endtask

   task automatic wr_txn(input logic [27:0] addr, input bit toggle, input bit also_read);
      int sent;
      int cyc;
      bit exp;
      DATA_write_addr = addr;
      DATA_store_req = 1'b1;
      if (also_read) begin
         DATA_read_req = 1'b1;
         DATA_read_addr = 28'($urandom);
      end
      tick;
      check("wr_state", 32'(state_interface_module), 9);
      check("wr_cmd_v", 32'(mem_cmd_valid), 1);
      check("wr_cmd_we", 32'(mem_cmd_we), 1);
      check("wr_cmd_a", 32'(mem_cmd_addr), 32'(addr));
      check("wr_cmd_len", 32'(mem_cmd_len), 16);
      mem_wr_ready = 1'b1;
      data_to_ddr_rdy = 1'b1;
      #1;
      check("wr_gate_cmd", 32'(wr_burst_data_req), 0);
      DATA_store_req = 1'($urandom_range(0, 1));
      DATA_read_req = 1'b0;
      mem_cmd_ready = 1'b1;
      tick;
      mem_cmd_ready = 1'b0;
      check("wr_cmd_ack", 32'(mem_cmd_valid), 0);
      sent = 0;
      cyc = 0;
      while (sent < 16 && cyc < 400) begin
         mem_wr_ready = toggle ? ((cyc % 2) == 0) : 1'($urandom_range(0, 1));
         data_to_ddr_rdy = toggle ? 1'b1 : 1'($urandom_range(0, 1));
         DATA_to_ddr = 16'($urandom);
         #1;
         exp = mem_wr_ready && data_to_ddr_rdy;
         check("wr_req", 32'(wr_burst_data_req), 32'(exp));
         check("wr_valid", 32'(mem_wr_valid), 32'(exp));
         if (exp) check("wr_data", 32'(mem_wr_data), 32'(DATA_to_ddr));
         check("wr_st_beats", 32'(state_interface_module), 9);
         tick;
         if (exp) sent++;
         cyc++;
      end
      if (cyc >= 400) check("wr_timeout", sent, 16);
      check("wr_done_st", 32'(state_interface_module), 10);
      mem_wr_ready = 1'b1;
      data_to_ddr_rdy = 1'b1;
      #1;
      check("wr_req_done", 32'(wr_burst_data_req), 0);
      check("wr_rdcnt", 32'(rd_cnt_data), 0);
      drop_reqs();
      tick;
      check("wr_back_idle", 32'(state_interface_module), 0);
      check("wr_req_idle", 32'(wr_burst_data_req), 0);
      mem_wr_ready = 1'b0;
      data_to_ddr_rdy = 1'b0;
   endtask

   initial begin
      rst = 1'b0;
      drop_reqs();
      DATA_read_addr = '0;
      DATA_write_addr = '0;
      DATA_to_ddr = '0;
      data_to_ddr_rdy = 1'b0;
      mem_cmd_ready = 1'b0;
      mem_rd_valid = 1'b0;
      mem_rd_data = '0;
      mem_wr_ready = 1'b0;
      #3;
      check_all_zero("reset");
      @(negedge clk) rst = 1'b1;
      tick;
      check("post_rst_st", 32'(state_interface_module), 0);

      rd_txn(1'b0, 28'h80, 0, 1'b0, 0, 1);
      wr_txn(28'h400, 1'b1, 1'b0);
      rd_txn(1'b1, 28'($urandom), 1, 1'b0, 0, 2);
      check("jmp_fixed", 32'(JMP_ADDR_to_cache), 32'h0ABCBEEF);
      wr_txn(28'($urandom), 1'b0, 1'b1);
      rd_txn(1'b0, 28'($urandom), 0, 1'b0, 0, 0);
      rd_txn(1'b0, 28'($urandom), 5, 1'b1, 0, 0);
      rd_txn(1'b0, 28'($urandom), 0, 1'b0, 7, 0);
      rd_txn(1'b0, 28'($urandom), 0, 1'b0, 0, 0);
      for (int k = 0; k < 8; k++) begin
         case ($urandom_range(0, 2))
            0: rd_txn(1'b0, 28'($urandom), $urandom_range(0, 3), 1'($urandom_range(0, 1)), 0, 0);
            1: rd_txn(1'b1, 28'($urandom), $urandom_range(0, 3), 1'($urandom_range(0, 1)), 0, 0);
            default: wr_txn(28'($urandom), 1'b0, 1'b0);
         endcase
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
